// File: rtl/mem_stage.sv
// MIPS memory stage: latches EX payload, aligns/merges load data, drives WB bus.
// Optional MS_RDATA_HOLD_EN keeps the first-cycle SRAM word across WB stalls.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 119,
  parameter int MS_TO_WS_BUS_WD = 83
) (
  input  logic                       clk,
  input  logic                       resetn,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [9:0]                 stall_ms_bus,
  output logic [32:0]                forward_ms_bus
);

  logic                       ms_valid;
  logic                       ms_ready_go;
  logic [ES_TO_MS_BUS_WD-1:0] bus_r;

  logic [2:0]  ld_type;
  logic        res_from_mem;
  logic        cp0_wen;
  logic        res_from_cp0;
  logic [7:0]  cp0_addr;
  logic [3:0]  gr_we;
  logic [4:0]  dest;
  logic [31:0] rt_value;
  logic [31:0] alu_result;
  logic [31:0] pc;

  assign {ld_type, res_from_mem, cp0_wen, res_from_cp0, cp0_addr,
          gr_we, dest, rt_value, alu_result, pc} = bus_r;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_r <= '0;
    end else if (es_to_ms_valid && ms_allowin) begin
      bus_r <= es_to_ms_bus;
    end
  end

  logic [31:0] rdata;

`ifdef MS_RDATA_HOLD_EN
  logic [31:0] rdata_r;
  logic        hold;

  // SRAM word is only valid in the load's first MEM cycle; keep it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold    <= 1'b0;
      rdata_r <= '0;
    end else if (ms_to_ws_valid && ws_allowin) begin
      hold    <= 1'b0;
    end else if (ms_valid && res_from_mem && !hold) begin
      hold    <= 1'b1;
      rdata_r <= data_sram_rdata;
    end
  end

  assign rdata = hold ? rdata_r : data_sram_rdata;
`else
  assign rdata = data_sram_rdata;
`endif

  logic [1:0]  k;
  logic        is_lb, is_lbu, is_lh, is_lhu, is_lwl, is_lwr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] lwl_data;
  logic [31:0] lwr_data;
  logic [3:0]  lwl_we;
  logic [3:0]  lwr_we;
  logic [31:0] merged;
  logic [3:0]  merge_we;
  logic [3:0]  we_eff;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign k      = alu_result[1:0];
  assign is_lb  = ld_type == 3'b001;
  assign is_lbu = ld_type == 3'b010;
  assign is_lh  = ld_type == 3'b011;
  assign is_lhu = ld_type == 3'b100;
  assign is_lwl = ld_type == 3'b101;
  assign is_lwr = ld_type == 3'b110;

  assign ld_byte  = rdata[{k, 3'b000} +: 8];
  assign ld_half  = k[1] ? rdata[31:16] : rdata[15:0];
  assign lwl_data = rdata << {~k, 3'b000};
  assign lwr_data = rdata >> {k, 3'b000};

  always_comb begin
    lwl_we = 4'b1111;
    lwr_we = 4'b1111;
    unique case (k)
      2'd0: begin lwl_we = 4'b1000; lwr_we = 4'b1111; end
      2'd1: begin lwl_we = 4'b1100; lwr_we = 4'b0111; end
      2'd2: begin lwl_we = 4'b1110; lwr_we = 4'b0011; end
      2'd3: begin lwl_we = 4'b1111; lwr_we = 4'b0001; end
      default: ;
    endcase
  end

  // Unwritten lanes come from rt so the forwarded value is the merged GPR.
  always_comb begin
    merge_we = is_lwl ? lwl_we : lwr_we;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = !merge_we[i] ? rt_value[8*i +: 8] :
                         is_lwl ? lwl_data[8*i +: 8] : lwr_data[8*i +: 8];
    end
  end

  always_comb begin
    load_data = rdata;
    unique case (1'b1)
      is_lb:           load_data = {{24{ld_byte[7]}}, ld_byte};
      is_lbu:          load_data = {24'd0, ld_byte};
      is_lh:           load_data = {{16{ld_half[15]}}, ld_half};
      is_lhu:          load_data = {16'd0, ld_half};
      is_lwl, is_lwr:  load_data = merged;
      default:         load_data = rdata;
    endcase
  end

  assign we_eff       = (res_from_mem && (is_lwl || is_lwr)) ? merge_we : gr_we;
  assign final_result = res_from_mem ? load_data : alu_result;

  assign ms_to_ws_bus   = {cp0_wen, res_from_cp0, cp0_addr, we_eff,
                           dest, final_result, pc};
  assign stall_ms_bus   = {ms_valid && |we_eff, we_eff & {4{ms_valid}}, dest};
  assign forward_ms_bus = {ms_valid, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Random + directed bench for mem_stage against a transaction-level model.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [118:0] es_to_ms_bus;
  logic [31:0]  data_sram_rdata;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [82:0]  ms_to_ws_bus;
  logic [9:0]   stall_ms_bus;
  logic [32:0]  forward_ms_bus;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_rdata (data_sram_rdata),
    .ws_allowin      (ws_allowin),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .stall_ms_bus    (stall_ms_bus),
    .forward_ms_bus  (forward_ms_bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic         m_valid = 1'b0;
  logic         m_first = 1'b0;
  logic [118:0] m_bus = '0;
  logic [31:0]  m_word = '0;

  task automatic chk(input string tag, input logic [82:0] got,
                     input logic [82:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [118:0] mk(
    input logic [2:0] ld, input logic rfm, input logic [3:0] we,
    input logic [4:0] dst, input logic [31:0] rt, input logic [31:0] alu);
    logic [31:0] pcv;
    pcv = 32'hBFC0_0000 + {alu[15:0], 2'b00};
    return {ld, rfm, 1'b0, 1'b0, 8'h00, we, dst, rt, alu, pcv};
  endfunction

  // Reference: derive the WB bus from the instruction and its memory word.
  function automatic logic [82:0] exp_out(input logic [118:0] b,
                                          input logic [31:0] w);
    logic [2:0]  ld;
    logic [31:0] rt, alu, res, mask, bv, hv;
    logic [3:0]  we;
    int          k;
    ld  = b[118:116];
    we  = b[104:101];
    rt  = b[95:64];
    alu = b[63:32];
    k   = int'(alu[1:0]);
    bv  = (w >> (8 * k)) & 32'hFF;
    hv  = (w >> (16 * (k / 2))) & 32'hFFFF;
    case (ld)
      3'd1: res = (bv >= 128) ? bv - 256 : bv;
      3'd2: res = bv;
      3'd3: res = (hv >= 32768) ? hv - 65536 : hv;
      3'd4: res = hv;
      3'd5: begin
        mask = 32'hFFFF_FFFF << (8 * (3 - k));
        res  = ((w << (8 * (3 - k))) & mask) | (rt & ~mask);
        if (b[115]) we = 4'(15 << (3 - k));
      end
      3'd6: begin
        mask = 32'hFFFF_FFFF >> (8 * k);
        res  = ((w >> (8 * k)) & mask) | (rt & ~mask);
        if (b[115]) we = 4'(15 >> k);
      end
      default: res = w;
    endcase
    if (!b[115]) res = alu;
    return {b[114], b[113], b[112:105], we, b[100:96], res, b[31:0]};
  endfunction

  // Called at posedge+1: drive, check, advance model, wait next posedge+1.
  task automatic cycle(input logic v, input logic [118:0] b,
                       input logic wa, input logic [31:0] word);
    logic [82:0] e;
    es_to_ms_valid = v;
    es_to_ms_bus   = b;
    ws_allowin     = wa;
`ifdef MS_RDATA_HOLD_EN
    data_sram_rdata = (m_valid && !m_first) ? $urandom : m_word;
`else
    data_sram_rdata = m_word;
`endif
    #1;
    chk("allowin", 83'(ms_allowin), 83'(!m_valid || wa));
    chk("valid", 83'(ms_to_ws_valid), 83'(m_valid));
    if (m_valid) begin
      e = exp_out(m_bus, m_word);
      chk("ws_bus", ms_to_ws_bus, e);
      chk("stall", 83'(stall_ms_bus), 83'({|e[72:69], e[72:69], e[68:64]}));
      chk("fwd", 83'(forward_ms_bus), 83'({1'b1, e[63:32]}));
    end else begin
      chk("stall_idle", 83'(stall_ms_bus[9:5]), 83'(0));
      chk("fwd_idle", 83'(forward_ms_bus[32]), 83'(0));
    end
    if (!m_valid || wa) begin
      m_valid = v;
      m_first = v;
      if (v) begin
        m_bus  = b;
        m_word = word;
      end
    end else begin
      m_first = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string tag, input logic [31:0] ef,
                      input logic [3:0] ewe);
    data_sram_rdata = m_word;
    #1;
    chk(tag, 83'(ms_to_ws_bus[63:32]), 83'(ef));
    chk({tag, "_we"}, 83'(ms_to_ws_bus[72:69]), 83'(ewe));
  endtask

  initial begin
    logic [118:0] b;
    resetn = 1'b0;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_rdata = '0;
    ws_allowin = 1'b1;
    #2;
    chk("rst_allowin", 83'(ms_allowin), 83'(1));
    chk("rst_valid", 83'(ms_to_ws_valid), 83'(0));
    chk("rst_stall", 83'(stall_ms_bus), 83'(0));
    chk("rst_fwd", 83'(forward_ms_bus[32]), 83'(0));
    @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;

    cycle(1, mk(3'd0, 1, 4'hF, 5'd2, 32'h0, 32'h1000), 1, 32'hDEADBEEF);
    peek("lw", 32'hDEADBEEF, 4'hF);
    chk("lw_valid", 83'(ms_to_ws_valid), 83'(1));
    cycle(1, mk(3'd1, 1, 4'hF, 5'd3, 32'h0, 32'h1003), 1, 32'h80123456);
    peek("lb", 32'hFFFFFF80, 4'hF);
    cycle(1, mk(3'd2, 1, 4'hF, 5'd3, 32'h0, 32'h1003), 1, 32'h80123456);
    peek("lbu", 32'h00000080, 4'hF);
    cycle(1, mk(3'd4, 1, 4'hF, 5'd3, 32'h0, 32'h1002), 1, 32'h80123456);
    peek("lhu", 32'h00008012, 4'hF);
    cycle(1, mk(3'd5, 1, 4'hF, 5'd4, 32'hAABBCCDD, 32'h1001), 1, 32'h11223344);
    peek("lwl", 32'h3344CCDD, 4'b1100);
    cycle(1, mk(3'd6, 1, 4'hF, 5'd4, 32'hAABBCCDD, 32'h1002), 1, 32'h11223344);
    peek("lwr", 32'hAABB1122, 4'b0011);
    cycle(1, mk(3'd0, 0, 4'h0, 5'd5, 32'h0, 32'h12345678), 1, 32'h0);
    #1;
    chk("nl_stall", 83'(stall_ms_bus), 83'(10'h005));
    chk("nl_fwd", 83'(forward_ms_bus), 83'({1'b1, 32'h12345678}));

    b = mk(3'd0, 1, 4'hF, 5'd6, 32'h0, 32'h2000);
    cycle(1, b, 1, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      cycle(0, '0, 0, 32'h0);
      chk("hold_res", 83'(ms_to_ws_bus[63:32]), 83'(32'hCAFEF00D));
    end
    cycle(0, '0, 1, 32'h0);
    chk("released", 83'(ms_to_ws_valid), 83'(0));

    cycle(1, b, 1, 32'h5555AAAA);
    cycle(0, '0, 0, 32'h0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", 83'(ms_to_ws_valid), 83'(0));
    chk("arst_stall", 83'(stall_ms_bus), 83'(0));
    m_valid = 1'b0;
    m_first = 1'b0;
    #2 resetn = 1'b1;
    #1;
    chk("arst_allowin", 83'(ms_allowin), 83'(1));
    @(posedge clk);
    #1;

    for (int i = 0; i < 800; i++) begin
      b = {3'($urandom), 1'($urandom), 2'($urandom), 8'($urandom),
           4'($urandom), 5'($urandom), 32'($urandom), 32'($urandom),
           32'($urandom)};
      cycle($urandom_range(0, 3) != 0, b, $urandom_range(0, 2) != 0, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS pipeline memory stage: the transmitting end of the MEM→WB bus consumed by wb_stage.
- Latches the EX→MEM payload and takes load data from the synchronous data SRAM.
- Aligns, sign-/zero-extends and merges load data; produces per-byte GPR write strobes.
- Drives ms_to_ws_valid/ms_to_ws_bus, plus stall and forward buses back to ID.

Parameters:
ES_TO_MS_BUS_WD, 119, EX→MEM payload width
MS_TO_WS_BUS_WD, 83, MEM→WB payload width

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
ms_allowin  out  1  MEM can accept from EX this cycle
es_to_ms_valid  in  1  EX payload valid
es_to_ms_bus  in  119  {ld_type[118:116], res_from_mem[115], cp0_wen[114], res_from_cp0[113], cp0_addr[112:105], gr_we[104:101], dest[100:96], rt_value[95:64], alu_result[63:32], pc[31:0]}
data_sram_rdata  in  32  load word; valid in the first cycle the load sits in MEM
ws_allowin  in  1  WB can accept
ms_to_ws_valid  out  1  MEM payload valid toward WB
ms_to_ws_bus  out  83  {cp0_wen[82], res_from_cp0[81], cp0_addr[80:73], gr_we[72:69], dest[68:64], final_result[63:32], pc[31:0]}
stall_ms_bus  out  10  {ms_valid && |gr_we, gr_we & {4{ms_valid}}, dest}
forward_ms_bus  out  33  {ms_valid, final_result}

Behaviour:
- Reset (async, resetn=0): ms_valid=0, payload register=0, hold flag=0.
- Outputs during reset: ms_allowin=1, ms_to_ws_valid=0, stall_ms_bus=0, forward_ms_bus[32]=0.
- Handshake:
  - ms_ready_go=1.
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
  - On posedge, if ms_allowin: ms_valid <= es_to_ms_valid.
  - Payload is captured only when es_to_ms_valid && ms_allowin. With ms_allowin=0, payload and ms_valid hold.
- Latency: one cycle EX→MEM; outputs are combinational from the payload register and rdata.
- ld_type encoding: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LWL, 110 LWR, 111 reserved (treated as LW). k = alu_result[1:0].
- Load data selection:
  - LB/LBU: byte k, sign-/zero-extended.
  - LH/LHU: halfword k[1]; k[0] ignored, no address error is raised here.
  - LWL: rdata << 8*(3-k); gr_we = 1000/1100/1110/1111 for k = 0/1/2/3.
  - LWR: rdata >> 8*k; gr_we = 1111/0111/0011/0001 for k = 0/1/2/3.
  - LWL/LWR final_result: unwritten byte lanes are filled from rt_value, so forwarded data equals the full post-merge register value.
  - All other loads: gr_we passes through from the payload.
- final_result = res_from_mem ? load_data : alu_result. CP0 fields pass through unchanged.
- A non-load with gr_we=0000 sets stall_ms_bus[9]=0.
- Back-to-back transfers at full rate with no bubble when ws_allowin=1.

Optional Feature:
Macro MS_RDATA_HOLD_EN.
- Defined:
  - A 32-bit rdata register and a hold flag are added.
  - In the first valid cycle of a res_from_mem instruction, data_sram_rdata is captured and the flag set.
  - While the flag is set, the captured value is used.
  - The flag clears when the instruction leaves MEM (ms_to_ws_valid && ws_allowin) or on reset.
  - Load results remain correct under arbitrary ws_allowin stalls.
- Undefined: data_sram_rdata is used combinationally every cycle. Correct only while ws_allowin=1 on load cycles.

Test Plan:
- LW, alu_result=0x1000, rdata=0xDEADBEEF, gr_we=1111 → next cycle ms_to_ws_valid=1, final_result=0xDEADBEEF, gr_we=1111.
- LB k=3, rdata=0x80123456 → final_result=0xFFFFFF80; same with LBU → 0x00000080; LHU k=2 → 0x00008012.
- LWL k=1, rdata=0x11223344, rt_value=0xAABBCCDD → gr_we=1100, final_result=0x3344CCDD. LWR k=2 same data → gr_we=0011, final_result=0xAABB1122.
- ws_allowin=0 for 3 cycles during a load (MS_RDATA_HOLD_EN defined), rdata changed to 0x0 after the first cycle → ms_allowin=0 throughout, payload held, final_result stays the original word, released on the cycle ws_allowin=1.
- Non-load, gr_we=0000, dest=5 → stall_ms_bus=0x005, forward_ms_bus[32]=1, final_result=alu_result.
- resetn asserted low asynchronously mid-stall with ms_valid=1 → ms_to_ws_valid=0 and stall_ms_bus=0 immediately (no clock edge needed); after release ms_allowin=1.
